// File: rtl/count_window_ctrl.sv
// -----------------------------------------------------------------------------
// count_window_ctrl
//
// Purpose:
//   Sequencer for a two-counter measurement. On request it preloads two
//   external up counters with a common start value, enables them for a
//   programmable number of cycles, waits one cycle for the final increment to
//   reach the counters' registered outputs, then compares the two counts and
//   reports the result with a one-cycle done pulse.
//
//   State sequence: IDLE -> LOAD -> COUNT (N cycles) -> SETTLE -> COMPARE
//                   -> DONE -> IDLE
//   A request accepted at cycle t produces done=1 at cycle t+N+4, where N is
//   the effective window length (a programmed length of 0 counts as 1).
//
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous active-high reset
//   start       in   1      measurement request, honoured only in IDLE
//   start_val   in   WIDTH  preload value for both counters
//   window_len  in   WIN_W  number of counting cycles
//   cnt_reset   out  1      load strobe for both counters (loads cnt_in)
//   cnt_enable  out  1      count enable for both counters
//   cnt_in      out  WIDTH  preload value driven to both counters
//   cnt_a_out   in   WIDTH  count from counter A
//   cnt_b_out   in   WIDTH  count from counter B
//   busy        out  1      high in every state except IDLE
//   done        out  1      one-cycle completion pulse
//   resp        out  1      A > B at compare time
//   tie         out  1      A == B at compare time
//   diff        out  WIDTH  |A - B| at compare time
//
//   All outputs are registered.
// -----------------------------------------------------------------------------
module count_window_ctrl #(
  parameter int WIDTH = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIN_W-1:0] window_len,
  output logic             cnt_reset,
  output logic             cnt_enable,
  output logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] cnt_a_out,
  input  logic [WIDTH-1:0] cnt_b_out,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic             tie,
  output logic [WIDTH-1:0] diff
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COUNT   = 3'd2,
    S_SETTLE  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state_r;
  logic [WIN_W-1:0] wcnt_r;       // remaining counting cycles
  logic [WIN_W-1:0] win_eff_s;    // window length with 0 mapped to 1
  logic             a_gt_b_s;
  logic             a_eq_b_s;
  logic [WIDTH-1:0] abs_diff_s;

  // Unsigned magnitude of the difference of two raw (possibly wrapped) counts.
  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  // Effective window length: a zero-length window still enables for one cycle.
  always_comb begin
    win_eff_s = window_len;
    if (window_len == {WIN_W{1'b0}}) begin
      win_eff_s = {{(WIN_W-1){1'b0}}, 1'b1};
    end else begin
      win_eff_s = window_len;
    end
  end

  // Comparison of the counter outputs; only captured in COMPARE. Equality
  // implies not-greater, so tie=1 always comes with resp=0.
  always_comb begin
    a_gt_b_s   = (cnt_a_out > cnt_b_out);
    a_eq_b_s   = (cnt_a_out == cnt_b_out);
    abs_diff_s = abs_diff(cnt_a_out, cnt_b_out);
  end

  // Main FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      wcnt_r     <= {WIN_W{1'b0}};
      cnt_reset  <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_in     <= {WIDTH{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      resp       <= 1'b0;
      tie        <= 1'b0;
      diff       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done       <= 1'b0;
          cnt_enable <= 1'b0;
          if (start) begin
            // Latch the run parameters now; later input changes are ignored.
            cnt_in    <= start_val;
            wcnt_r    <= win_eff_s;
            cnt_reset <= 1'b1;
            busy      <= 1'b1;
            state_r   <= S_LOAD;
          end else begin
            cnt_reset <= 1'b0;
            busy      <= 1'b0;
          end
        end

        S_LOAD: begin
          cnt_reset  <= 1'b0;
          cnt_enable <= 1'b1;
          state_r    <= S_COUNT;
        end

        S_COUNT: begin
          // wcnt_r holds the cycles left including the current one.
          if (wcnt_r <= {{(WIN_W-1){1'b0}}, 1'b1}) begin
            wcnt_r     <= {WIN_W{1'b0}};
            cnt_enable <= 1'b0;
            state_r    <= S_SETTLE;
          end else begin
            wcnt_r     <= wcnt_r - {{(WIN_W-1){1'b0}}, 1'b1};
          end
        end

        S_SETTLE: begin
          // Counters register their last increment during this cycle.
          state_r <= S_COMPARE;
        end

        S_COMPARE: begin
          resp    <= a_gt_b_s;
          tie     <= a_eq_b_s;
          diff    <= abs_diff_s;
          done    <= 1'b1;
          state_r <= S_DONE;
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end

        default: begin
          // Unreachable encodings recover to a quiet IDLE.
          state_r    <= S_IDLE;
          wcnt_r     <= {WIN_W{1'b0}};
          cnt_reset  <= 1'b0;
          cnt_enable <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_window_ctrl
//
// Directed bench for count_window_ctrl. Two behavioural up counters sit on the
// counter interface: A increments every enabled cycle, B every second enabled
// cycle (or every cycle when b_same is set). Each accepted run pushes its
// expected result, latency and enable-cycle count into a scoreboard; the
// monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_count_window_ctrl;

  localparam int WIDTH = 8;
  localparam int WIN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] start_val = 8'h00;
  logic [WIN_W-1:0] window_len = 16'd0;
  logic             cnt_reset;
  logic             cnt_enable;
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cnt_a_out;
  logic [WIDTH-1:0] cnt_b_out;
  logic             busy;
  logic             done;
  logic             resp;
  logic             tie;
  logic [WIDTH-1:0] diff;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;

  typedef struct {
    logic             resp;
    logic             tie;
    logic [WIDTH-1:0] diff;
    int               done_cyc;
    int               n;
  } exp_t;

  exp_t sb_q[$];

  // counter models
  logic [WIDTH-1:0] a_m = 8'h00;
  logic [WIDTH-1:0] b_m = 8'h00;
  logic             ph = 1'b0;
  logic             b_same = 1'b0;

  assign cnt_a_out = a_m;
  assign cnt_b_out = b_m;

  count_window_ctrl #(.WIDTH(WIDTH), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_val(start_val),
    .window_len(window_len), .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
    .cnt_in(cnt_in), .cnt_a_out(cnt_a_out), .cnt_b_out(cnt_b_out),
    .busy(busy), .done(done), .resp(resp), .tie(tie), .diff(diff)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cnt_reset) begin
      a_m <= cnt_in;
      b_m <= cnt_in;
      ph  <= 1'b0;
    end else if (cnt_enable) begin
      a_m <= a_m + 8'd1;
      if (b_same || ph) b_m <= b_m + 8'd1;
      ph <= ~ph;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: count enabled cycles per run and score each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (cnt_reset) en_cnt = 0;
    else if (cnt_enable) en_cnt = en_cnt + 1;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("resp", int'(resp), int'(e.resp));
        check("tie", int'(tie), int'(e.tie));
        check("diff", int'(diff), int'(e.diff));
        check("latency", cyc, e.done_cyc);
        check("enable_cycles", en_cnt, e.n);
      end
    end
  end

  // Issue a request from IDLE, push its expected outcome, check LOAD outputs.
  task automatic do_run(input logic [WIDTH-1:0] sv, input logic [WIN_W-1:0] wl);
    exp_t e;
    int n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    n = (wl == 16'd0) ? 1 : int'(wl);
    a = sv + WIDTH'(n);
    b = sv + (b_same ? WIDTH'(n) : WIDTH'(n / 2));
    e.resp = (a > b);
    e.tie  = (a == b);
    e.diff = (a >= b) ? (a - b) : (b - a);
    e.n    = n;
    @(negedge clk);
    start_val  = sv;
    window_len = wl;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.done_cyc = cyc + n + 3;
    sb_q.push_back(e);
    check("load_cnt_reset", int'(cnt_reset), 1);
    check("load_cnt_enable", int'(cnt_enable), 0);
    check("load_cnt_in", int'(cnt_in), int'(sv));
    check("load_busy", int'(busy), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) break;
    end
    check("run_timeout", sb_q.size(), 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_resp", int'(resp), 0);
    check("rst_tie", int'(tie), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_cnt_enable", int'(cnt_enable), 0);
    check("rst_cnt_reset", int'(cnt_reset), 0);
    check("rst_cnt_in", int'(cnt_in), 0);
    reset = 1'b0;
    @(negedge clk);

    // basic: A=10, B=5
    b_same = 1'b0;
    do_run(8'h00, 16'd10);
    wait_idle();

    // wrap: A=0x04, B=0xFF
    do_run(8'hFA, 16'd10);
    wait_idle();

    // identical counters -> tie
    b_same = 1'b1;
    do_run(8'h10, 16'd20);
    wait_idle();
    b_same = 1'b0;

    // zero window -> one enabled cycle, done at t+5
    do_run(8'h33, 16'd0);
    wait_idle();

    // start and parameter changes during COUNT are ignored
    do_run(8'h05, 16'd6);
    repeat (2) @(negedge clk);
    start      = 1'b1;
    window_len = 16'd3;
    start_val  = 8'h99;
    @(negedge clk);
    start = 1'b0;
    check("midrun_cnt_in", int'(cnt_in), 8'h05);
    wait_idle();
    repeat (20) @(negedge clk);

    // reset mid-COUNT aborts the run
    do_run(8'h20, 16'd30);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    void'(sb_q.pop_back());
    check("abort_busy", int'(busy), 0);
    check("abort_cnt_enable", int'(cnt_enable), 0);
    check("abort_done", int'(done), 0);
    check("abort_resp", int'(resp), 0);
    check("abort_tie", int'(tie), 0);
    check("abort_diff", int'(diff), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // normal run after abort: A=5, B=3
    do_run(8'h01, 16'd4);
    wait_idle();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_window_ctrl.md
COUNT_WINDOW_CTRL -- requirements
Module: count_window_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of counter preload and counter outputs.
REQ-002 Parameter WIN_W, default 16: width of window_len.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  measurement request; sampled only in IDLE.
REQ-006 start_val  input  WIDTH  preload value for both counters.
REQ-007 window_len  input  WIN_W  number of counting cycles.
REQ-008 cnt_reset  output  1  drives reset of both up counters (loads cnt_in).
REQ-009 cnt_enable  output  1  drives enable of both up counters.
REQ-010 cnt_in  output  WIDTH  drives preload input of both up counters.
REQ-011 cnt_a_out  input  WIDTH  count from counter A.
REQ-012 cnt_b_out  input  WIDTH  count from counter B.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 resp  output  1  response bit, 1 when A count > B count.
REQ-016 tie  output  1  1 when A count == B count.
REQ-017 diff  output  WIDTH  |A - B| of sampled counts.

Function
REQ-018 FSM states: IDLE, LOAD, COUNT, SETTLE, COMPARE, DONE; one-hot or binary encoding is implementation choice.
REQ-019 IDLE: start=1 -> LOAD; latch start_val and window_len into internal registers in the same cycle.
REQ-020 start while not IDLE: ignored, no queuing; start_val/window_len changes after acceptance: no effect on current run.
REQ-021 LOAD: exactly 1 cycle; cnt_reset=1, cnt_enable=0, cnt_in=latched start_val; -> COUNT.
REQ-022 COUNT: cnt_enable=1, cnt_reset=0 for exactly latched window_len cycles, tracked by a WIN_W-bit down-counter; -> SETTLE.
REQ-023 window_len=0: treated as 1 (cnt_enable high exactly 1 cycle).
REQ-024 SETTLE: 1 cycle, cnt_enable=0, so the final increment is visible on registered counter outputs.
REQ-025 COMPARE: sample cnt_a_out/cnt_b_out; register resp=(A>B), tie=(A==B), diff=(A>=B ? A-B : B-A), all unsigned WIDTH-bit; -> DONE.
REQ-026 DONE: done=1 for 1 cycle; -> IDLE.
REQ-027 Latency: start accepted at cycle t -> done=1 at cycle t+N+4, N = effective window length.
REQ-028 resp, tie, diff update only in COMPARE; hold value until next COMPARE or reset; valid while done=1.
REQ-029 cnt_in holds latched start_val in all states; cnt_reset/cnt_enable=0 in all states other than LOAD/COUNT respectively.
REQ-030 Counter wrap-around is not detected; comparison uses raw wrapped WIDTH-bit values.
REQ-031 tie=1 forces resp=0.

Reset
REQ-032 reset=1 at any clock edge: next state IDLE, aborting any run, no done pulse.
REQ-033 Reset values: busy=0, done=0, resp=0, tie=0, diff=0, cnt_enable=0, cnt_reset=0, cnt_in=0, internal window counter=0.
REQ-034 reset has priority over start in the same cycle.

Verification
REQ-035 Bench models counter A incrementing every enabled cycle and counter B on every second enabled cycle; both load cnt_in on cnt_reset.
REQ-036 start_val=0x00, window_len=10 -> A=10, B=5; resp=1, tie=0, diff=5, done exactly 14 cycles after start accepted.
REQ-037 start_val=0xFA, window_len=10 -> A wraps to 0x04, B=0xFF; resp=0, tie=0, diff=0xFB.
REQ-038 Both counter models identical, window_len=20 -> tie=1, resp=0, diff=0.
REQ-039 window_len=0 -> cnt_enable high exactly 1 cycle, done at t+5; start pulsed during COUNT and window_len changed mid-run -> ignored, single done.
REQ-040 reset asserted mid-COUNT -> next cycle busy=0, cnt_enable=0, no done; resp/tie/diff=0; subsequent start runs normally.
